register_scoreboard: RTL and testbench

Tracks outstanding register writes between issue (ID→EXE) and writeback (WB), and raises `hazard` when the instruction in ID reads a register whose write is still in flight. It complements the stage-comparison hazard check from the producer side: destinations are recorded on issue and released on retire. The pipeline treats `hazard` as a stall-and-bubble request for IF/ID. It also exposes per-register pending state and sticky error flags for debug.

---
 rtl/register_scoreboard_if.sv | 35 +++
 rtl/register_scoreboard.sv | 92 +++++++++
 tb/tb_register_scoreboard.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/register_scoreboard_if.sv
// Pipeline-to-scoreboard bundle: ID source operands, issue/retire events,
// and the hazard, pending-state and error outputs of the scoreboard.
interface register_scoreboard_if #(
    parameter int ID_WIDTH  = 4,
    parameter int REG_COUNT = 16
);
    logic                 forwardingEnabled;
    logic                 twoSrc;
    logic [ID_WIDTH-1:0]  src1;
    logic [ID_WIDTH-1:0]  src2;
    logic                 issueValid;
    logic                 issueWriteBackEnabled;
    logic [ID_WIDTH-1:0]  issueDestination;
    logic                 retireValid;
    logic [ID_WIDTH-1:0]  retireDestination;
    logic                 hazard;
    logic [REG_COUNT-1:0] pendingMask;
    logic                 busy;
    logic                 errorOverflow;
    logic                 errorUnderflow;

    modport master (
        output forwardingEnabled, twoSrc, src1, src2,
        output issueValid, issueWriteBackEnabled, issueDestination,
        output retireValid, retireDestination,
        input  hazard, pendingMask, busy, errorOverflow, errorUnderflow
    );

    modport slave (
        input  forwardingEnabled, twoSrc, src1, src2,
        input  issueValid, issueWriteBackEnabled, issueDestination,
        input  retireValid, retireDestination,
        output hazard, pendingMask, busy, errorOverflow, errorUnderflow
    );
endinterface

// File: rtl/register_scoreboard.sv
// Per-register count of in-flight writes between issue and writeback; raises
// a stall request when the instruction in ID reads a register still being produced.
module register_scoreboard #(
    parameter int REG_COUNT   = 16,
    parameter int ID_WIDTH    = 4,
    parameter int COUNT_WIDTH = 2
) (
    input logic                  clk,
    input logic                  rst,
    register_scoreboard_if.slave sb
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic [COUNT_WIDTH-1:0] count_q [REG_COUNT];
    logic [COUNT_WIDTH-1:0] count_d [REG_COUNT];
    logic                   exe_valid_q, exe_valid_d;
    logic [ID_WIDTH-1:0]    exe_destination_q, exe_destination_d;
    logic                   error_overflow_q, error_overflow_d;
    logic                   error_underflow_q, error_underflow_d;

    logic                   hazard;
    logic                   hazard_fwd;
    logic                   hazard_nofwd;
    logic                   issue_accept;
    logic [REG_COUNT-1:0]   pending_mask;

    // A write retiring this cycle is already readable (write-through register file).
    function automatic logic still_pending(input logic [COUNT_WIDTH-1:0] cnt,
                                           input logic                   retiring);
        return (cnt != '0) && !((cnt == COUNT_WIDTH'(1)) && retiring);
    endfunction

    always_comb begin
        hazard_nofwd = still_pending(count_q[sb.src1],
                                     sb.retireValid && (sb.retireDestination == sb.src1))
                     || (sb.twoSrc && still_pending(count_q[sb.src2],
                                     sb.retireValid && (sb.retireDestination == sb.src2)));
        hazard_fwd   = exe_valid_q && ((sb.src1 == exe_destination_q)
                                    || (sb.twoSrc && (sb.src2 == exe_destination_q)));
        hazard       = sb.forwardingEnabled ? hazard_fwd : hazard_nofwd;
        issue_accept = sb.issueValid && sb.issueWriteBackEnabled && !hazard;
    end

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
        error_overflow_d  = error_overflow_q;
        error_underflow_d = error_underflow_q;
        exe_valid_d       = issue_accept;
        exe_destination_d = sb.issueDestination;
        for (int i = 0; i < REG_COUNT; i++) begin
            logic inc;
            logic dec;
            inc        = issue_accept && (sb.issueDestination == ID_WIDTH'(i));
            dec        = sb.retireValid && (sb.retireDestination == ID_WIDTH'(i));
            count_d[i] = count_q[i];
            if (inc && !dec) begin
                if (count_q[i] == COUNT_MAX) error_overflow_d = 1'b1;
                else                         count_d[i] = count_q[i] + COUNT_WIDTH'(1);
            end else if (dec && !inc) begin
                if (count_q[i] == '0) error_underflow_d = 1'b1;
                else                  count_d[i] = count_q[i] - COUNT_WIDTH'(1);
            end
            pending_mask[i] = (count_q[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the count array is architectural state, not storage; it must reset like any flop.
            for (int i = 0; i < REG_COUNT; i++) count_q[i] <= '0;
            exe_valid_q       <= 1'b0;
            exe_destination_q <= '0;
            error_overflow_q  <= 1'b0;
            error_underflow_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops sample together.
            count_q           <= count_d;
            exe_valid_q       <= exe_valid_d;
            exe_destination_q <= exe_destination_d;
            error_overflow_q  <= error_overflow_d;
            error_underflow_q <= error_underflow_d;
        end
    end

    assign sb.hazard         = hazard;
    assign sb.pendingMask    = pending_mask;
    assign sb.busy           = |pending_mask;
    assign sb.errorOverflow  = error_overflow_q;
    assign sb.errorUnderflow = error_underflow_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed and randomized checks of register_scoreboard against an integer
// model of in-flight writes per register.
module tb_register_scoreboard;

    localparam int REG_COUNT = 16;
    localparam int ID_WIDTH  = 4;
    localparam int MAX_CNT   = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Reference state: number of writes in flight per register.
    int   m_count [REG_COUNT];
    bit   m_exe_valid;
    int   m_exe_dest;
    bit   m_ovf;
    bit   m_udf;

    register_scoreboard_if #(.ID_WIDTH(ID_WIDTH), .REG_COUNT(REG_COUNT)) bus ();

    register_scoreboard #(
        .REG_COUNT  (REG_COUNT),
        .ID_WIDTH   (ID_WIDTH),
        .COUNT_WIDTH(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_pending(input int r);
        int retiring;
        retiring = (bus.retireValid && int'(bus.retireDestination) == r) ? 1 : 0;
        return (m_count[r] - retiring) > 0;
    endfunction

    function automatic bit m_hazard();
        if (bus.forwardingEnabled)
            return m_exe_valid && (int'(bus.src1) == m_exe_dest ||
                                   (bus.twoSrc && int'(bus.src2) == m_exe_dest));
        return m_pending(int'(bus.src1)) || (bus.twoSrc && m_pending(int'(bus.src2)));
    endfunction

    function automatic logic [REG_COUNT-1:0] m_mask();
        logic [REG_COUNT-1:0] m;
        for (int r = 0; r < REG_COUNT; r++) m[r] = (m_count[r] > 0);
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample point (mid-cycle, inputs stable) and model comparison.
    task automatic settle();
        #4;
        check("hazard",   32'(bus.hazard),         32'(m_hazard()));
        check("mask",     32'(bus.pendingMask),    32'(m_mask()));
        check("busy",     32'(bus.busy),           32'(m_mask() != '0));
        check("overflow", 32'(bus.errorOverflow),  32'(m_ovf));
        check("underflow",32'(bus.errorUnderflow), 32'(m_udf));
    endtask

    // Clock edge plus the matching model update.
    task automatic advance();
        bit accept;
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < REG_COUNT; r++) m_count[r] = 0;
            m_exe_valid = 0;
            m_exe_dest  = 0;
            m_ovf       = 0;
            m_udf       = 0;
        end else begin
            accept = bus.issueValid && bus.issueWriteBackEnabled && !m_hazard();
            for (int r = 0; r < REG_COUNT; r++) begin
                int next;
                next = m_count[r]
                     + ((accept && int'(bus.issueDestination) == r) ? 1 : 0)
                     - ((bus.retireValid && int'(bus.retireDestination) == r) ? 1 : 0);
                if (next > MAX_CNT) begin m_ovf = 1; next = MAX_CNT; end
                if (next < 0)       begin m_udf = 1; next = 0;       end
                m_count[r] = next;
            end
            m_exe_valid = accept;
            m_exe_dest  = int'(bus.issueDestination);
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.twoSrc                = 1'b0;
        bus.src1                  = '0;
        bus.src2                  = '0;
        bus.issueValid            = 1'b0;
        bus.issueWriteBackEnabled = 1'b0;
        bus.issueDestination      = '0;
        bus.retireValid           = 1'b0;
        bus.retireDestination     = '0;
    endtask

    task automatic issue(input int dest);
        bus.issueValid            = 1'b1;
        bus.issueWriteBackEnabled = 1'b1;
        bus.issueDestination      = ID_WIDTH'(dest);
    endtask

    task automatic retire(input int dest);
        bus.retireValid       = 1'b1;
        bus.retireDestination = ID_WIDTH'(dest);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        advance();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int r = 0; r < REG_COUNT; r++) m_count[r] = 0;
        m_exe_valid = 0; m_exe_dest = 0; m_ovf = 0; m_udf = 0;
        rst = 1'b1;
        bus.forwardingEnabled = 1'b0;
        idle_inputs();
        #1;

        // Reset then idle.
        do_reset();
        settle();
        check("rst_hazard", 32'(bus.hazard), 32'd0);
        check("rst_mask",   32'(bus.pendingMask), 32'h0000);
        check("rst_busy",   32'(bus.busy), 32'd0);
        check("rst_errors", {30'd0, bus.errorOverflow, bus.errorUnderflow}, 32'd0);
        advance();

        // Non-forwarding: R3 issued at edge 0 stalls a reader for cycles 1-2.
        bus.forwardingEnabled = 1'b0;
        issue(3);
        settle(); advance();
        idle_inputs(); bus.src1 = 4'd3;
        settle(); check("nofwd_c1", 32'(bus.hazard), 32'd1); advance();
        settle(); check("nofwd_c2", 32'(bus.hazard), 32'd1); advance();
        retire(3);
        settle();
        check("nofwd_c3_hz",   32'(bus.hazard), 32'd0);
        check("nofwd_c3_mask", 32'(bus.pendingMask[3]), 32'd1);
        advance();
        idle_inputs(); bus.src1 = 4'd3;
        settle(); check("nofwd_c4_mask", 32'(bus.pendingMask[3]), 32'd0); advance();

        // Forwarding: only the previous-cycle issue stalls.
        do_reset();
        bus.forwardingEnabled = 1'b1;
        issue(5);
        settle(); advance();
        idle_inputs(); bus.twoSrc = 1'b1; bus.src2 = 4'd5;
        settle(); check("fwd_c1", 32'(bus.hazard), 32'd1); advance();
        settle(); check("fwd_c2", 32'(bus.hazard), 32'd0); advance();
        issue(5); bus.twoSrc = 1'b0; bus.src2 = 4'd0;
        settle(); advance();
        idle_inputs(); bus.twoSrc = 1'b0; bus.src2 = 4'd5;
        settle(); check("fwd_one_src", 32'(bus.hazard), 32'd0); advance();

        // Overflow on R7, then drain to confirm count held at 3.
        do_reset();
        bus.forwardingEnabled = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle_inputs(); issue(7); settle(); advance();
        end
        settle(); check("ovf_before", 32'(bus.errorOverflow), 32'd0);
        idle_inputs(); issue(7); settle(); advance();
        idle_inputs();
        settle(); check("ovf_set", 32'(bus.errorOverflow), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("ovf_drain_mask", 32'(bus.pendingMask[7]), 32'd1);
            idle_inputs(); retire(7); settle(); advance();
        end
        idle_inputs();
        settle(); check("ovf_drained", 32'(bus.pendingMask[7]), 32'd0);
        issue(7); settle(); advance();
        idle_inputs(); issue(7); retire(7); bus.src1 = 4'd1; settle(); advance();
        idle_inputs(); retire(7); settle(); advance();
        idle_inputs();
        settle();
        check("same_cycle_mask", 32'(bus.pendingMask[7]), 32'd0);
        check("same_cycle_udf",  32'(bus.errorUnderflow), 32'd0);
        advance();

        // Underflow on R2 is sticky until reset.
        retire(2); settle(); advance();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            settle(); check("udf_sticky", 32'(bus.errorUnderflow), 32'd1); advance();
        end
        do_reset();
        settle(); check("udf_cleared", 32'(bus.errorUnderflow), 32'd0); advance();

        // Reset mid-operation wins over a simultaneous issue and retire.
        bus.forwardingEnabled = 1'b1;
        issue(1); settle(); advance();
        idle_inputs(); issue(9); settle(); advance();
        idle_inputs(); issue(4); retire(1);
        rst = 1'b1;
        advance();
        rst = 1'b0;
        idle_inputs();
        bus.forwardingEnabled = 1'b0;
        bus.src1 = 4'd4; bus.twoSrc = 1'b1; bus.src2 = 4'd9;
        settle();
        check("midrst_mask",   32'(bus.pendingMask), 32'h0000);
        check("midrst_hazard", 32'(bus.hazard), 32'd0);
        advance();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if (($urandom % 50) == 0) bus.forwardingEnabled = ~bus.forwardingEnabled;
            bus.twoSrc                = 1'($urandom);
            bus.src1                  = ID_WIDTH'($urandom_range(0, 15));
            bus.src2                  = ID_WIDTH'($urandom_range(0, 15));
            bus.issueValid            = ($urandom % 3) != 0;
            bus.issueWriteBackEnabled = ($urandom % 4) != 0;
            bus.issueDestination      = ID_WIDTH'($urandom_range(0, 15));
            bus.retireValid           = ($urandom % 3) != 0;
            bus.retireDestination     = ID_WIDTH'($urandom_range(0, 15));
            rst = (($urandom % 80) == 0);
            settle();
            advance();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
